// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types, default timing constants and parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } ps2_state_e;

  localparam int c_inhibit_cycles = 6000;     // 120 us at 50 MHz
  localparam int c_timeout_cycles = 1000000;  // 20 ms at 50 MHz
  localparam int c_filter_len     = 5;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_edge_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_edge_filter
// Description : Pad synchronizers plus a glitch-rejecting PS/2 clock falling
//               edge detector (FILTER_LEN stable samples on each side).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_edge_filter #(
  parameter int FILTER_LEN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_negedge
);

  localparam int c_hist_len = 2 * FILTER_LEN;

  logic                  r_clk_meta;
  logic                  r_clk_sync;
  logic                  r_dat_meta;
  logic                  r_dat_sync;
  logic [c_hist_len-1:0] r_hist;
  logic                  w_negedge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_hist     <= '1;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_dat;
      r_dat_sync <= r_dat_meta;
      r_hist     <= {r_hist[c_hist_len-2:0], r_clk_sync};
    end
  end

  // Newest sample sits in bit 0; the pattern only matches for one cycle.
  assign w_negedge = (r_hist[FILTER_LEN-1:0] == '0) &&
                     (r_hist[c_hist_len-1:FILTER_LEN] == '1);

  assign o_clk_sync = r_clk_sync;
  assign o_dat_sync = r_dat_sync;
  assign o_negedge  = w_negedge;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (request-to-send,
//               device-clocked shifting, parity, stop, ACK check, timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = c_inhibit_cycles,
  parameter int TIMEOUT_CYCLES = c_timeout_cycles,
  parameter int FILTER_LEN     = c_filter_len
) (
  input  logic       clk_50,
  input  logic       areset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int c_inh_w  = $clog2(INHIBIT_CYCLES) + 1;
  localparam int c_to_w   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int c_idle_w = $clog2(FILTER_LEN) + 1;

  localparam logic [c_inh_w-1:0]  c_inh_last  = c_inh_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_inh_w-1:0]  c_inh_start = c_inh_w'(INHIBIT_CYCLES - 2);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(FILTER_LEN - 1);

  ps2_state_e          r_state;
  ps2_state_e          w_state_nxt;
  logic [c_inh_w-1:0]  r_inh_cnt;
  logic [c_inh_w-1:0]  w_inh_cnt_nxt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [c_to_w-1:0]   w_to_cnt_nxt;
  logic [c_idle_w-1:0] r_idle_cnt;
  logic [c_idle_w-1:0] w_idle_cnt_nxt;
  logic [3:0]          r_bit_cnt;
  logic [3:0]          w_bit_cnt_nxt;
  logic [8:0]          r_frame;
  logic [8:0]          w_frame_nxt;
  logic                r_ack_ok;
  logic                w_ack_ok_nxt;
  logic                r_clk_oe;
  logic                r_dat_oe;
  logic                w_dat_oe_nxt;
  logic                r_tx_ready;
  logic                r_tx_done;
  logic                w_done_nxt;
  logic                r_tx_error;
  logic                w_error_nxt;
  logic                w_timing;
  logic                w_timeout;

  logic w_clk_sync;
  logic w_dat_sync;
  logic w_dev_negedge;

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_filter (
    .clk        (clk_50),
    .rst        (areset),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_dat  (ps2_dat_in),
    .o_clk_sync (w_clk_sync),
    .o_dat_sync (w_dat_sync),
    .o_negedge  (w_dev_negedge)
  );

  assign w_timing  = r_state inside {REQ, SHIFT, STOP, ACK, WAIT_IDLE};
  assign w_timeout = w_timing && (r_to_cnt == c_to_last);

  always_comb begin
    w_state_nxt    = r_state;
    w_inh_cnt_nxt  = r_inh_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_frame_nxt    = r_frame;
    w_ack_ok_nxt   = r_ack_ok;
    w_dat_oe_nxt   = r_dat_oe;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;

    if (w_timing) begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        w_dat_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_frame_nxt   = {odd_parity(tx_data), tx_data};
          w_inh_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = INHIBIT;
        end
      end
      INHIBIT: begin
        w_inh_cnt_nxt = r_inh_cnt + 1'b1;
        // Start bit goes low while the clock is still held, on the final cycle.
        if (r_inh_cnt == c_inh_start) begin
          w_dat_oe_nxt = 1'b1;
        end
        if (r_inh_cnt == c_inh_last) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = REQ;
        end
      end
      REQ: begin
        if (w_dev_negedge) begin
          w_dat_oe_nxt  = ~r_frame[0];
          w_bit_cnt_nxt = 4'd1;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_dev_negedge) begin
          w_dat_oe_nxt  = ~r_frame[r_bit_cnt];
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd8) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_dev_negedge) begin
          w_dat_oe_nxt = 1'b0;
          w_state_nxt  = ACK;
        end
      end
      ACK: begin
        if (w_dev_negedge) begin
          w_ack_ok_nxt   = ~w_dat_sync;
          w_idle_cnt_nxt = '0;
          w_state_nxt    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        w_dat_oe_nxt = 1'b0;
        if (w_clk_sync && w_dat_sync) begin
          if (r_idle_cnt == c_idle_last) begin
            w_done_nxt     = r_ack_ok;
            w_error_nxt    = ~r_ack_ok;
            w_idle_cnt_nxt = '0;
            w_state_nxt    = IDLE;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
          end
        end else begin
          w_idle_cnt_nxt = '0;
        end
      end
      default: begin
        w_dat_oe_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase

    // A timeout overrides anything the device did on the same cycle.
    if (w_timeout) begin
      w_state_nxt  = IDLE;
      w_dat_oe_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      w_error_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (areset) begin
      r_state    <= IDLE;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_idle_cnt <= '0;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_ack_ok   <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inh_cnt  <= w_inh_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_frame    <= w_frame_nxt;
      r_ack_ok   <= w_ack_ok_nxt;
      r_clk_oe   <= (w_state_nxt == INHIBIT);
      r_dat_oe   <= w_dat_oe_nxt;
      r_tx_ready <= (w_state_nxt == IDLE);
      r_tx_done  <= w_done_nxt;
      r_tx_error <= w_error_nxt;
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign tx_ready   = r_tx_ready;
  assign tx_done    = r_tx_done;
  assign tx_error   = r_tx_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 keyboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int C_INH  = 200;
  localparam int C_TO   = 3000;
  localparam int C_FL   = 5;
  localparam int C_HALF = 40;

  logic       clk_50 = 1'b0;
  logic       areset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done, tx_error;
  wire        ps2_clk_in, ps2_dat_in;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch_low  = 1'b0;
  int   dev_mode    = 0;     // 0 ack, 1 no ack, 2 silent, 3 abort after 4 clocks
  bit   dev_glitch  = 1'b0;
  bit   dev_aborted = 1'b0;

  logic [9:0] exp_frame_q[$];
  logic [1:0] exp_out_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #10 clk_50 = ~clk_50;

  // Open-drain bus: any party pulling low wins.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (C_INH),
    .TIMEOUT_CYCLES (C_TO),
    .FILTER_LEN     (C_FL)
  ) dut (
    .clk_50     (clk_50),
    .areset     (areset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Keyboard model: answers a request-to-send, samples on its rising edges.
  task automatic run_frame();
    logic [9:0] bits;
    int nclk;
    bits = '0;
    nclk = (dev_mode == 3) ? 4 : 11;
    repeat (C_HALF) @(negedge clk_50);
    for (int i = 0; i < nclk; i++) begin
      dev_clk_low = 1'b1;
      repeat (C_HALF) @(negedge clk_50);
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_dat_in;
      if (i == 9 && dev_mode == 0) begin
        repeat (C_HALF / 2) @(negedge clk_50);
        dev_dat_low = 1'b1;
        repeat (C_HALF / 2) @(negedge clk_50);
      end else if (i == 5 && dev_glitch) begin
        repeat (10) @(negedge clk_50);
        glitch_low = 1'b1;
        repeat (3) @(negedge clk_50);
        glitch_low = 1'b0;
        repeat (C_HALF - 13) @(negedge clk_50);
      end else begin
        repeat (C_HALF) @(negedge clk_50);
      end
    end
    dev_dat_low = 1'b0;
    if (dev_mode == 3) dev_aborted = 1'b1;
    else if (exp_frame_q.size() == 0) chk("frame_unexpected", 32'(exp_frame_q.size()), 32'd1);
    else chk("frame_bits", 32'(bits), 32'(exp_frame_q.pop_front()));
  endtask

  initial begin
    forever begin
      @(negedge clk_50);
      if (ps2_clk_oe === 1'b1) begin
        while (ps2_clk_oe === 1'b1) @(negedge clk_50);
        if (dev_mode != 2 && ps2_dat_in === 1'b0) run_frame();
      end
    end
  end

  // Outcome scoreboard: every done/error pulse must match the queued result.
  always @(negedge clk_50) begin
    if (areset === 1'b0 && (tx_done === 1'b1 || tx_error === 1'b1)) begin
      chk("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
      if (exp_out_q.size() == 0) chk("outcome_unexpected", 32'({tx_done, tx_error}), 32'd0);
      else chk("outcome", 32'({tx_done, tx_error}), 32'(exp_out_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] b, input bit push_frame, input bit push_out,
                      input logic [1:0] outc);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk_50);
      n++;
    end
    chk("ready_before_send", 32'(tx_ready), 32'd1);
    if (push_frame) exp_frame_q.push_back({1'b1, ~^b, b});
    if (push_out) exp_out_q.push_back(outc);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk_50);
    tx_valid = 1'b0;
    chk("ready_low_after_accept", 32'(tx_ready), 32'd0);
  endtask

  task automatic wait_outcome(input int budget);
    int n;
    n = 0;
    while (!(tx_done === 1'b1 || tx_error === 1'b1) && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    chk("outcome_seen", 32'(tx_done | tx_error), 32'd1);
    @(negedge clk_50);
  endtask

  initial begin
    int cnt, first;
    areset   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (5) @(negedge clk_50);
    chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    chk("reset_tx_done", 32'(tx_done), 32'd0);
    chk("reset_tx_error", 32'(tx_error), 32'd0);
    areset = 1'b0;
    repeat (5) @(negedge clk_50);

    // 0xED with inhibit timing measurement
    send(8'hED, 1'b1, 1'b1, 2'b10);
    cnt   = 0;
    first = -1;
    while (ps2_clk_oe === 1'b1 && cnt < C_INH + 20) begin
      if (ps2_dat_oe === 1'b1 && first < 0) first = cnt;
      cnt++;
      @(negedge clk_50);
    end
    chk("inhibit_length", 32'(cnt), 32'(C_INH));
    chk("start_bit_cycle", 32'(first), 32'(C_INH - 1));
    chk("start_bit_held", 32'(ps2_dat_oe), 32'd1);
    chk("clk_released_high", 32'(ps2_clk_in), 32'd1);
    wait_outcome(4000);

    send(8'h01, 1'b1, 1'b1, 2'b10);
    wait_outcome(4000);
    send(8'hFF, 1'b1, 1'b1, 2'b10);
    wait_outcome(4000);

    // 0x00 while tx_valid is held busy with other data
    send(8'h00, 1'b1, 1'b1, 2'b10);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (300) @(negedge clk_50);
    chk("busy_ready_low", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    wait_outcome(4000);
    repeat (20) @(negedge clk_50);
    chk("no_extra_frame", 32'(ps2_clk_oe), 32'd0);

    // short clock glitch mid-frame must not advance the bit counter
    dev_glitch = 1'b1;
    send(8'hF3, 1'b1, 1'b1, 2'b10);
    wait_outcome(4000);
    dev_glitch = 1'b0;

    // missing ACK
    dev_mode = 1;
    send(8'h12, 1'b1, 1'b1, 2'b01);
    wait_outcome(4000);
    chk("noack_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("noack_dat_oe", 32'(ps2_dat_oe), 32'd0);
    chk("noack_ready", 32'(tx_ready), 32'd1);

    // silent device -> timeout measured from clock release
    dev_mode = 2;
    send(8'hAA, 1'b0, 1'b1, 2'b01);
    cnt = 0;
    while (ps2_clk_oe === 1'b1 && cnt < C_INH + 50) begin
      @(negedge clk_50);
      cnt++;
    end
    cnt = 0;
    while (tx_error !== 1'b1 && cnt < C_TO + 100) begin
      @(negedge clk_50);
      cnt++;
    end
    chk("timeout_cycles", 32'(cnt), 32'(C_TO));
    chk("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
    @(negedge clk_50);

    // reset after four data bits (all zero, so data is being driven low)
    dev_mode    = 3;
    dev_aborted = 1'b0;
    send(8'h30, 1'b0, 1'b0, 2'b00);
    cnt = 0;
    while (!dev_aborted && cnt < 3000) begin
      @(negedge clk_50);
      cnt++;
    end
    chk("abort_reached", 32'(dev_aborted), 32'd1);
    chk("abort_dat_driven", 32'(ps2_dat_oe), 32'd1);
    areset = 1'b1;
    @(posedge clk_50);
    #1;
    chk("midreset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("midreset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    @(negedge clk_50);
    areset   = 1'b0;
    dev_mode = 0;
    repeat (5) @(negedge clk_50);
    send(8'hF4, 1'b1, 1'b1, 2'b10);
    wait_outcome(4000);

    repeat (50) @(negedge clk_50);
    chk("frames_left", 32'(exp_frame_q.size()), 32'd0);
    chk("outcomes_left", 32'(exp_out_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation did not complete, observed running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
